// File: rtl/bitcoin_result_scan.sv
// rtl/bitcoin_result_scan.sv - scans nonce hash results in memory for target hits and minimum, writes a summary word
//
// Reads NUM_NONCES consecutive 32-bit result words starting at output_addr over
// a single-port synchronous memory (two-edge read latency), counts the words
// strictly below target, tracks the minimum word and its index, then writes one
// summary word at output_addr + NUM_NONCES and pulses done for one cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 start request, sampled only when idle
//   output_addr[15:0]     base address of the result array, sampled on start
//   target[31:0]          unsigned hit threshold, sampled on start
//   done                  one-cycle completion pulse
//   found                 at least one word below target
//   hit_count[7:0]        number of words below target
//   best_nonce[7:0]       index of the minimum word (lowest index on ties)
//   best_hash[31:0]       value of the minimum word
//   mem_clk               memory clock, identical to clk
//   mem_we                memory write enable
//   mem_addr[15:0]        memory address
//   mem_write_data[31:0]  memory write data
//   mem_read_data[31:0]   memory read data

module bitcoin_result_scan #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] output_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [7:0]  hit_count,
    output logic [7:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WB   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [7:0]  NUM_W   = 8'(NUM_NONCES);
    localparam logic [7:0]  LAST_W  = 8'(NUM_NONCES - 1);
    localparam logic [15:0] WB_OFFS = 16'(NUM_NONCES);

    state_t      state;
    logic [15:0] base_q;
    logic [31:0] target_q;
    logic [7:0]  issue_cnt;
    logic [7:0]  cap_cnt;
    // Read data lags the address by two edges, so the first READ edge has
    // nothing to capture yet; this flag marks that the pipeline is filled.
    logic        primed;

    logic        word_hit;
    logic        word_better;

    assign mem_clk = clk;

    // Index 0 always seeds the minimum; later words must be strictly smaller
    // so that ties keep the lowest index.
    assign word_hit    = (mem_read_data < target_q);
    assign word_better = (cap_cnt == 8'd0) || (mem_read_data < best_hash);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            base_q         <= 16'd0;
            target_q       <= 32'd0;
            issue_cnt      <= 8'd0;
            cap_cnt        <= 8'd0;
            primed         <= 1'b0;
            done           <= 1'b0;
            found          <= 1'b0;
            hit_count      <= 8'd0;
            best_nonce     <= 8'd0;
            best_hash      <= 32'd0;
            mem_we         <= 1'b0;
            mem_addr       <= 16'd0;
            mem_write_data <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q     <= output_addr;
                        target_q   <= target;
                        mem_addr   <= output_addr;
                        mem_we     <= 1'b0;
                        hit_count  <= 8'd0;
                        found      <= 1'b0;
                        best_nonce <= 8'd0;
                        best_hash  <= 32'd0;
                        issue_cnt  <= 8'd1;
                        cap_cnt    <= 8'd0;
                        primed     <= 1'b0;
                        state      <= READ;
                    end
                end

                READ: begin
                    // Address side: one new address per cycle, wrapping mod 2^16.
                    if (issue_cnt < NUM_W) begin
                        mem_addr  <= base_q + {8'd0, issue_cnt};
                        issue_cnt <= issue_cnt + 8'd1;
                    end

                    // Capture side: starts one edge after entering READ.
                    if (primed) begin
                        if (word_hit) begin
                            hit_count <= hit_count + 8'd1;
                            found     <= 1'b1;
                        end
                        if (word_better) begin
                            best_hash  <= mem_read_data;
                            best_nonce <= cap_cnt;
                        end
                        cap_cnt <= cap_cnt + 8'd1;
                        if (cap_cnt == LAST_W) begin
                            state <= WB;
                        end
                    end else begin
                        primed <= 1'b1;
                    end
                end

                WB: begin
                    // Result registers already hold the last capture here.
                    mem_we         <= 1'b1;
                    mem_addr       <= base_q + WB_OFFS;
                    mem_write_data <= {found, 7'd0, hit_count, 8'd0, best_nonce};
                    state          <= FIN;
                end

                FIN: begin
                    mem_we <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitcoin_result_scan.sv
// tb/tb_bitcoin_result_scan.sv - self-checking bench for bitcoin_result_scan

module tb_bitcoin_result_scan;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] output_addr = 16'd0;
    logic [31:0] target = 32'd0;
    logic        done;
    logic        found;
    logic [7:0]  hit_count;
    logic [7:0]  best_nonce;
    logic [31:0] best_hash;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    bitcoin_result_scan #(.NUM_NONCES(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .output_addr    (output_addr),
        .target         (target),
        .done           (done),
        .found          (found),
        .hit_count      (hit_count),
        .best_nonce     (best_nonce),
        .best_hash      (best_hash),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory model: read contents written by the bench, writes from the DUT logged.
    logic [31:0] bmem [0:65535];
    logic [31:0] rd_q = 32'd0;
    int          wr_count = 0;
    int          done_count = 0;
    logic [15:0] wr_addr_log = 16'd0;
    logic [31:0] wr_data_log = 32'd0;

    always @(posedge clk) begin
        rd_q <= bmem[mem_addr];
        if (mem_we) begin
            wr_count++;
            wr_addr_log <= mem_addr;
            wr_data_log <= mem_write_data;
        end
        if (done) done_count++;
    end
    assign mem_read_data = rd_q;

    typedef struct {
        logic        found;
        logic [7:0]  hit;
        logic [7:0]  nonce;
        logic [31:0] hash;
        logic [15:0] wb_addr;
        logic [31:0] wb_data;
    } exp_t;

    typedef struct {
        logic [15:0] base;
        logic [31:0] target;
        int          kind;
        logic        has_exp;
        logic        e_found;
        logic [7:0]  e_hit;
        logic [7:0]  e_nonce;
        logic [31:0] e_hash;
        logic [15:0] e_wb_addr;
        logic [31:0] e_wb_data;
    } vec_t;

    vec_t vecs [6];
    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [15:0] base, input int kind);
        for (int i = 0; i < N; i++) begin
            logic [15:0] a;
            a = base + 16'(i);
            case (kind)
                0: bmem[a] = 32'hF000_0000 - 32'(i);
                1: bmem[a] = 32'h0000_0010;
                2: bmem[a] = (i == 9) ? 32'h0000_0001 : 32'hFFFF_FFFF;
                3: bmem[a] = $urandom;
                default: bmem[a] = 32'($urandom_range(0, 3));
            endcase
        end
    endtask

    function automatic exp_t model(input logic [15:0] base, input logic [31:0] tgt);
        exp_t e;
        e.found = 1'b0;
        e.hit = 8'd0;
        e.nonce = 8'd0;
        e.hash = 32'd0;
        for (int i = 0; i < N; i++) begin
            logic [31:0] w;
            w = bmem[base + 16'(i)];
            if (w < tgt) begin
                e.hit = e.hit + 8'd1;
                e.found = 1'b1;
            end
            if (i == 0 || w < e.hash) begin
                e.hash = w;
                e.nonce = 8'(i);
            end
        end
        e.wb_addr = base + 16'(N);
        e.wb_data = {e.found, 7'd0, e.hit, 8'd0, e.nonce};
        return e;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_scan(input int vi);
        vec_t v;
        exp_t e;
        int   cyc;
        int   w0;
        v = vecs[vi];
        fill(v.base, v.kind);
        sb.push_back(model(v.base, v.target));
        w0 = wr_count;
        @(negedge clk);
        output_addr = v.base;
        target = v.target;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        output_addr = 16'($urandom);
        target = $urandom;
        wait_done(cyc);
        e = sb.pop_front();
        chk($sformatf("v%0d done_seen", vi), 32'(done), 32'd1);
        chk($sformatf("v%0d latency", vi), 32'(cyc), 32'(N + 3));
        chk($sformatf("v%0d found", vi), 32'(found), 32'(e.found));
        chk($sformatf("v%0d hit_count", vi), 32'(hit_count), 32'(e.hit));
        chk($sformatf("v%0d best_nonce", vi), 32'(best_nonce), 32'(e.nonce));
        chk($sformatf("v%0d best_hash", vi), best_hash, e.hash);
        chk($sformatf("v%0d writes", vi), 32'(wr_count - w0), 32'd1);
        chk($sformatf("v%0d wb_addr", vi), 32'(wr_addr_log), 32'(e.wb_addr));
        chk($sformatf("v%0d wb_data", vi), wr_data_log, e.wb_data);
        if (v.has_exp) begin
            chk($sformatf("v%0d tbl_found", vi), 32'(found), 32'(v.e_found));
            chk($sformatf("v%0d tbl_hit", vi), 32'(hit_count), 32'(v.e_hit));
            chk($sformatf("v%0d tbl_nonce", vi), 32'(best_nonce), 32'(v.e_nonce));
            chk($sformatf("v%0d tbl_hash", vi), best_hash, v.e_hash);
            chk($sformatf("v%0d tbl_wb_addr", vi), 32'(wr_addr_log), 32'(v.e_wb_addr));
            chk($sformatf("v%0d tbl_wb_data", vi), wr_data_log, v.e_wb_data);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d done_pulse", vi), 32'(done), 32'd0);
        chk($sformatf("v%0d hold_hash", vi), best_hash, e.hash);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " found"}, 32'(found), 32'd0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, " hit_count"}, 32'(hit_count), 32'd0);
        chk({tag, " best_nonce"}, 32'(best_nonce), 32'd0);
        chk({tag, " best_hash"}, best_hash, 32'd0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, " mem_write_data"}, mem_write_data, 32'd0);
    endtask

    initial begin
        int   cyc;
        int   w0;
        int   d0;
        exp_t e;

        vecs[0] = '{16'h0100, 32'hFFFF_FFFF, 0, 1'b1, 1'b1, 8'd16, 8'd15, 32'hEFFF_FFF1, 16'h0110, 32'h8010_000F};
        vecs[1] = '{16'h0200, 32'h0000_0010, 1, 1'b1, 1'b0, 8'd0, 8'd0, 32'h0000_0010, 16'h0210, 32'h0000_0000};
        vecs[2] = '{16'hFFF8, 32'h0000_0010, 2, 1'b1, 1'b1, 8'd1, 8'd9, 32'h0000_0001, 16'h0008, 32'h8001_0009};
        vecs[3] = '{16'h1234, 32'h8000_0000, 3, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0, 16'd0, 32'd0};
        vecs[4] = '{16'hFFFF, 32'h0000_0002, 4, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0, 16'd0, 32'd0};
        vecs[5] = '{16'h0000, 32'h0000_0000, 3, 1'b0, 1'b0, 8'd0, 8'd0, 32'd0, 16'd0, 32'd0};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        chk("mem_clk", 32'(mem_clk), 32'(clk));
        @(negedge clk);
        reset_n = 1'b1;

        for (int vi = 0; vi < 6; vi++) begin
            run_scan(vi);
        end

        // start held high through READ: exactly one write-back and one done.
        fill(16'h0300, 0);
        e = model(16'h0300, 32'hFFFF_FFFF);
        w0 = wr_count;
        d0 = done_count;
        @(negedge clk);
        output_addr = 16'h0300;
        target = 32'hFFFF_FFFF;
        start = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("proto no_write_in_read", 32'(wr_count - w0), 32'd0);
        chk("proto mem_we_in_read", 32'(mem_we), 32'd0);
        start = 1'b0;
        wait_done(cyc);
        chk("proto done_seen", 32'(done), 32'd1);
        chk("proto best_hash", best_hash, e.hash);
        repeat (30) @(posedge clk);
        #1;
        chk("proto writes", 32'(wr_count - w0), 32'd1);
        chk("proto dones", 32'(done_count - d0), 32'd1);

        // Reset asserted at edge 7 of a scan, then a clean restart.
        fill(16'h0500, 3);
        w0 = wr_count;
        d0 = done_count;
        @(negedge clk);
        output_addr = 16'h0500;
        target = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("midreset writes", 32'(wr_count - w0), 32'd0);
        chk("midreset dones", 32'(done_count - d0), 32'd0);
        chk("midreset idle_hash", best_hash, 32'd0);
        run_scan(3);
        run_scan(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
